iter_divider: RTL and testbench
===============================

Name: iter_divider

Overview:
- Multi-cycle restoring divider: the inverse of the single-cycle ALU multiply path.
- Serves the CPU's DIV/DIVU instructions.
- Accepts a dividend/divisor pair with a start pulse and iterates one quotient bit per clock.
- Returns quotient and remainder with a one-cycle done pulse; the pipeline stalls on busy_o.

Parameters:
- WIDTH, 32, operand/result width in bits; iteration count equals WIDTH.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- start_i  input  1  request; sampled only in IDLE.
- dividend_i  input  WIDTH  dividend; captured on the accepting edge.
- divisor_i  input  WIDTH  divisor; captured on the accepting edge.
- quotient_o  output  WIDTH  registered quotient of the last completed operation.
- remainder_o  output  WIDTH  registered remainder of the last completed operation.
- busy_o  output  1  high in CALC and DONE states.
- done_o  output  1  one-cycle pulse; results are valid from this cycle on.
- div_zero_o  output  1  registered; high when the last completed operation had divisor 0.
- zero_o  output  1  combinational: quotient_o == 0.

Behaviour:
- Reset (rst_i high at an edge):
  - State goes to IDLE.
  - quotient_o=0, remainder_o=0, done_o=0, busy_o=0, div_zero_o=0, zero_o=1.
  - Iteration counter and working registers are cleared.
  - Reset mid-CALC aborts the operation; no done_o pulse follows.
- States: IDLE, CALC, DONE.
- IDLE:
  - start_i=1 with divisor_i!=0: latch operands, set remainder accumulator=0, counter=0, go to CALC.
  - start_i=1 with divisor_i==0: go directly to DONE, loading quotient_o=all ones, remainder_o=dividend_i, div_zero_o=1.
  - start_i=0: stay in IDLE.
- CALC (one step per edge):
  - Shift {acc, dvd} left by 1.
  - Trial = acc - divisor, computed at WIDTH+1 bits.
  - If trial is non-negative: acc=trial and the quotient LSB is 1; otherwise acc is unchanged and the LSB is 0.
  - After WIDTH steps (counter==WIDTH-1 at the edge): register quotient_o/remainder_o, div_zero_o=0, go to DONE.
- DONE:
  - done_o=1 for exactly one cycle, then IDLE.
  - start_i is ignored in DONE; a new request is accepted one cycle later, in IDLE.
- Latency:
  - Normal: done_o is high in the cycle after the WIDTH-th edge following the accepting edge (33 cycles start-to-done for WIDTH=32).
  - Divide-by-zero: done_o is high in the cycle immediately after the accepting edge.
- start_i while busy_o=1 is ignored; no queueing.
- quotient_o, remainder_o and div_zero_o hold their previous values throughout CALC and change only on the edge entering DONE.
- Operand inputs may change freely after the accepting edge.
- All arithmetic is unsigned modulo 2^WIDTH; the invariant dividend = quotient*divisor + remainder holds, with remainder < divisor.

Optional Feature:
- Macro: ITER_DIVIDER_SIGNED_EN.
- Defined:
  - Adds input port signed_i (1 bit), captured on the accepting edge.
  - When signed_i=1: operands are converted to magnitudes before CALC; quotient is negated if operand signs differ; remainder takes the dividend's sign (MIPS DIV semantics).
  - Most-negative / -1 (0x80000000 / 0xFFFFFFFF) yields quotient 0x80000000, remainder 0, div_zero_o=0.
  - Signed divide-by-zero behaves as the unsigned case (quotient all ones, remainder = dividend).
  - Latency is unchanged.
- Undefined:
  - No signed_i port; unsigned only.

Test Plan:
- Reset then idle: rst_i=1 for 2 cycles -> quotient_o=0, remainder_o=0, busy_o=0, done_o=0, zero_o=1.
- 100/7 -> after 33 cycles done_o=1 for one cycle, quotient_o=14, remainder_o=2, zero_o=0, div_zero_o=0; busy_o high for exactly 33 cycles.
- 0xFFFFFFFF/1 then 5/9 back-to-back (second start asserted while busy, then re-asserted in IDLE):
  - first yields quotient 0xFFFFFFFF, remainder 0;
  - the start asserted while busy is ignored;
  - second yields quotient 0 (zero_o=1), remainder 5.
- 1234/0 -> done_o in the cycle after start; quotient_o=0xFFFFFFFF, remainder_o=1234, div_zero_o=1; the next valid divide clears div_zero_o at its done.
- Reset asserted at cycle 10 of 1000/3 -> IDLE, outputs zero, no done_o pulse; a fresh 1000/3 then yields quotient 333, remainder 1.
- With ITER_DIVIDER_SIGNED_EN, signed_i=1:
  - -7/2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1);
  - 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0.

Source files
------------

// File: rtl/iter_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, done_o pulses WIDTH+1 cycles after accept.
// Optional macro ITER_DIVIDER_SIGNED_EN adds signed_i (MIPS DIV semantics); default build is unsigned only.
module iter_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
`ifdef ITER_DIVIDER_SIGNED_EN
    input  logic             signed_i,
`endif
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_zero_o,
    output logic             zero_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dsr;
    logic [CW-1:0]    cnt;
    logic             last_step;
    logic [WIDTH:0]   acc_sh;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] dvd_nxt;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;

`ifdef ITER_DIVIDER_SIGNED_EN
    logic neg_q;
    logic neg_r;
    logic in_neg_a;
    logic in_neg_b;
`endif

    assign last_step = (cnt == CW'(WIDTH - 1));
    assign busy_o    = (state != IDLE);
    assign done_o    = (state == DONE);
    assign zero_o    = (quotient_o == '0);

    // One restoring step: acc stays below divisor, so WIDTH+1 bits hold the shifted value.
    always_comb begin
        acc_sh  = {acc, dvd[WIDTH-1]};
        trial   = acc_sh - {1'b0, dsr};
        acc_nxt = trial[WIDTH] ? acc_sh[WIDTH-1:0] : trial[WIDTH-1:0];
        dvd_nxt = {dvd[WIDTH-2:0], ~trial[WIDTH]};
    end

`ifdef ITER_DIVIDER_SIGNED_EN
    always_comb begin
        in_neg_a = signed_i & dividend_i[WIDTH-1];
        in_neg_b = signed_i & divisor_i[WIDTH-1];
        mag_a    = in_neg_a ? -dividend_i : dividend_i;
        mag_b    = in_neg_b ? -divisor_i : divisor_i;
        // Most-negative / -1 falls out naturally: magnitude 2^(W-1) negates to itself.
        q_fin    = neg_q ? -dvd_nxt : dvd_nxt;
        r_fin    = neg_r ? -acc_nxt : acc_nxt;
    end
`else
    always_comb begin
        mag_a = dividend_i;
        mag_b = divisor_i;
        q_fin = dvd_nxt;
        r_fin = acc_nxt;
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_nxt = (divisor_i == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc         <= '0;
            dvd         <= '0;
            dsr         <= '0;
            cnt         <= '0;
            quotient_o  <= '0;
            remainder_o <= '0;
            div_zero_o  <= 1'b0;
`ifdef ITER_DIVIDER_SIGNED_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        if (divisor_i == '0) begin
                            quotient_o  <= '1;
                            remainder_o <= dividend_i;
                            div_zero_o  <= 1'b1;
                        end else begin
                            acc <= '0;
                            dvd <= mag_a;
                            dsr <= mag_b;
                            cnt <= '0;
`ifdef ITER_DIVIDER_SIGNED_EN
                            neg_q <= in_neg_a ^ in_neg_b;
                            neg_r <= in_neg_a;
`endif
                        end
                    end
                end
                CALC: begin
                    acc <= acc_nxt;
                    dvd <= dvd_nxt;
                    cnt <= cnt + 1'b1;
                    if (last_step) begin
                        quotient_o  <= q_fin;
                        remainder_o <= r_fin;
                        div_zero_o  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_divider.sv
// Directed self-checking bench for iter_divider; inputs driven and outputs sampled on the falling edge.
module tb_iter_divider;

    localparam int W = 32;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic [W-1:0]  dividend_i;
    logic [W-1:0]  divisor_i;
`ifdef ITER_DIVIDER_SIGNED_EN
    logic          signed_i;
`endif
    logic [W-1:0]  quotient_o;
    logic [W-1:0]  remainder_o;
    logic          busy_o;
    logic          done_o;
    logic          div_zero_o;
    logic          zero_o;

    int checks = 0;
    int errors = 0;

    iter_divider #(.WIDTH(W)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
`ifdef ITER_DIVIDER_SIGNED_EN
        .signed_i    (signed_i),
`endif
        .quotient_o  (quotient_o),
        .remainder_o (remainder_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .div_zero_o  (div_zero_o),
        .zero_o      (zero_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Pulses start for one cycle, scrambles operands afterwards, waits (bounded) for done_o.
    // cyc = cycles from the start cycle to the done cycle; bc = cycles with busy_o high.
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, output int cyc, output int bc);
        @(negedge clk_i);
        start_i    = 1'b1;
        dividend_i = a;
        divisor_i  = b;
        @(negedge clk_i);
        start_i    = 1'b0;
        dividend_i = $urandom;
        divisor_i  = $urandom;
        cyc = 1;
        bc  = 0;
        while (!done_o && cyc < 100) begin
            if (busy_o) bc++;
            @(negedge clk_i);
            cyc++;
        end
        if (busy_o) bc++;
    endtask

    initial begin
        int cyc;
        int bc;
        int seen;

        rst_i      = 1'b1;
        start_i    = 1'b0;
        dividend_i = '0;
        divisor_i  = '0;
`ifdef ITER_DIVIDER_SIGNED_EN
        signed_i   = 1'b0;
`endif
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        chk("rst_quot", quotient_o, 32'd0);
        chk("rst_rem", remainder_o, 32'd0);
        chk("rst_busy", W'(busy_o), 32'd0);
        chk("rst_done", W'(done_o), 32'd0);
        chk("rst_zero", W'(zero_o), 32'd1);
        chk("rst_dz", W'(div_zero_o), 32'd0);

        // 100 / 7
        do_div(32'd100, 32'd7, cyc, bc);
        chk("d100_lat", W'(cyc), 32'd33);
        chk("d100_busy_cnt", W'(bc), 32'd33);
        chk("d100_quot", quotient_o, 32'd14);
        chk("d100_rem", remainder_o, 32'd2);
        chk("d100_zero", W'(zero_o), 32'd0);
        chk("d100_dz", W'(div_zero_o), 32'd0);
        @(negedge clk_i);
        chk("d100_done_pulse", W'(done_o), 32'd0);
        chk("d100_idle", W'(busy_o), 32'd0);

        // 0xFFFFFFFF / 1 with a stray start while busy and another during DONE
        @(negedge clk_i);
        start_i    = 1'b1;
        dividend_i = 32'hFFFF_FFFF;
        divisor_i  = 32'd1;
        @(negedge clk_i);
        start_i = 1'b0;
        cyc = 1;
        repeat (4) @(negedge clk_i);
        cyc += 4;
        start_i    = 1'b1;
        dividend_i = 32'd5;
        divisor_i  = 32'd9;
        @(negedge clk_i);
        cyc++;
        start_i = 1'b0;
        while (!done_o && cyc < 100) begin
            @(negedge clk_i);
            cyc++;
        end
        chk("max_lat", W'(cyc), 32'd33);
        chk("max_quot", quotient_o, 32'hFFFF_FFFF);
        chk("max_rem", remainder_o, 32'd0);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("start_in_done_ignored", W'(busy_o), 32'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk_i);
            if (busy_o || done_o) seen++;
        end
        chk("start_in_busy_ignored", W'(seen), 32'd0);

        do_div(32'd5, 32'd9, cyc, bc);
        chk("d5_lat", W'(cyc), 32'd33);
        chk("d5_quot", quotient_o, 32'd0);
        chk("d5_rem", remainder_o, 32'd5);
        chk("d5_zero", W'(zero_o), 32'd1);

        // Divide by zero
        do_div(32'd1234, 32'd0, cyc, bc);
        chk("dz_lat", W'(cyc), 32'd1);
        chk("dz_quot", quotient_o, 32'hFFFF_FFFF);
        chk("dz_rem", remainder_o, 32'd1234);
        chk("dz_flag", W'(div_zero_o), 32'd1);
        @(negedge clk_i);
        chk("dz_done_pulse", W'(done_o), 32'd0);

        // A valid divide keeps old results during CALC, then clears div_zero_o
        start_i    = 1'b1;
        dividend_i = 32'd20;
        divisor_i  = 32'd4;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("hold_busy", W'(busy_o), 32'd1);
        chk("hold_quot", quotient_o, 32'hFFFF_FFFF);
        chk("hold_dz", W'(div_zero_o), 32'd1);
        cyc = 1;
        while (!done_o && cyc < 100) begin
            @(negedge clk_i);
            cyc++;
        end
        chk("d20_lat", W'(cyc), 32'd33);
        chk("d20_quot", quotient_o, 32'd5);
        chk("d20_rem", remainder_o, 32'd0);
        chk("d20_dz_cleared", W'(div_zero_o), 32'd0);

        // Previous result with non-zero remainder, then reset mid-CALC
        do_div(32'd23, 32'd5, cyc, bc);
        chk("d23_rem", remainder_o, 32'd3);
        @(negedge clk_i);
        start_i    = 1'b1;
        dividend_i = 32'd1000;
        divisor_i  = 32'd3;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (9) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("abort_quot", quotient_o, 32'd0);
        chk("abort_rem", remainder_o, 32'd0);
        chk("abort_busy", W'(busy_o), 32'd0);
        chk("abort_zero", W'(zero_o), 32'd1);
        seen = 0;
        repeat (40) begin
            @(negedge clk_i);
            if (done_o) seen++;
        end
        chk("abort_no_done", W'(seen), 32'd0);

        do_div(32'd1000, 32'd3, cyc, bc);
        chk("d1000_lat", W'(cyc), 32'd33);
        chk("d1000_quot", quotient_o, 32'd333);
        chk("d1000_rem", remainder_o, 32'd1);

`ifdef ITER_DIVIDER_SIGNED_EN
        signed_i = 1'b1;
        do_div(32'hFFFF_FFF9, 32'd2, cyc, bc);
        chk("s_m7_lat", W'(cyc), 32'd33);
        chk("s_m7_quot", quotient_o, 32'hFFFF_FFFD);
        chk("s_m7_rem", remainder_o, 32'hFFFF_FFFF);
        do_div(32'h8000_0000, 32'hFFFF_FFFF, cyc, bc);
        chk("s_min_quot", quotient_o, 32'h8000_0000);
        chk("s_min_rem", remainder_o, 32'd0);
        chk("s_min_dz", W'(div_zero_o), 32'd0);
        do_div(32'hFFFF_FFF9, 32'd0, cyc, bc);
        chk("s_dz_quot", quotient_o, 32'hFFFF_FFFF);
        chk("s_dz_rem", remainder_o, 32'hFFFF_FFF9);
        signed_i = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
